xaui_tx_idle_gen: RTL and testbench



---
 rtl/xaui_pkg.sv | 26 ++
 rtl/xaui_col_enc.sv | 97 +++++++++
 rtl/xaui_tx_idle_gen.sv | 113 +++++++++++
 tb/tb_xaui_tx_idle_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xaui_pkg.sv
// Shared XAUI transmit code constants, column state encoding and idle-randomisation LFSR helper.
package xaui_pkg;

    localparam logic [7:0] CODE_I = 8'h07;
    localparam logic [7:0] CODE_S = 8'hFB;
    localparam logic [7:0] CODE_T = 8'hFD;
    localparam logic [7:0] CODE_E = 8'hFE;
    localparam logic [7:0] CODE_Q = 8'h9C;
    localparam logic [7:0] CODE_K = 8'hBC;
    localparam logic [7:0] CODE_R = 8'h1C;
    localparam logic [7:0] CODE_A = 8'h7C;

    // x^7 + x^6 + 1
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PKT    = 2'd1,
        ST_POST_T = 2'd2
    } col_state_e;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/xaui_col_enc.sv
// Combinational encoder for one XGMII column: control-code validation, /T/-column
// idle replacement and ||A||/||K||/||R|| selection for full idle columns.
module xaui_col_enc
    import xaui_pkg::*;
#(
    parameter int A_MIN = 16
) (
    input  logic        en,
    input  logic [1:0]  state_in,
    input  logic [4:0]  a_cnt,
    input  logic [3:0]  lfsr,
    input  logic [31:0] txd,
    input  logic [3:0]  txc,
    output logic [31:0] data_out,
    output logic [3:0]  k_out,
    output logic        err,
    output logic [1:0]  state_out,
    output logic [4:0]  a_cnt_next
);

    col_state_e state_cur;
    col_state_e state_next;
    logic [3:0] is_t;
    logic       has_t;
    logic       has_s0;
    logic       idle_col;
    logic [7:0] idle_code;
    logic [7:0] b;

    assign state_cur = col_state_e'(state_in);
    assign state_out = state_next;

    for (genvar gi = 0; gi < 4; gi++) begin : g_t_lane
        assign is_t[gi] = txc[gi] && (txd[8*gi +: 8] == CODE_T);
    end

    assign has_t    = en && (|is_t);
    assign has_s0   = en && txc[0] && (txd[7:0] == CODE_S);
    assign idle_col = !en || ((txc == 4'hF) && (txd == {4{CODE_I}}));

    always_comb begin
        data_out   = '0;
        k_out      = '0;
        err        = 1'b0;
        idle_code  = CODE_K;
        b          = '0;
        state_next = state_cur;
        a_cnt_next = (a_cnt == 5'd0) ? 5'd0 : a_cnt - 5'd1;

        if (idle_col) begin
            // The reload column also counts as one elapsed column, so the
            // next ||A|| lands exactly A_MIN + lfsr[3:0] columns later.
            if (a_cnt == 5'd0) begin
                idle_code  = CODE_A;
                a_cnt_next = 5'(A_MIN - 1) + {1'b0, lfsr};
            end else if (state_cur == ST_POST_T || lfsr[0]) begin
                idle_code = CODE_K;
            end else begin
                idle_code = CODE_R;
            end
            data_out = {4{idle_code}};
            k_out    = 4'hF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                b = txd[8*i +: 8];
                if (!txc[i]) begin
                    data_out[8*i +: 8] = b;
                end else begin
                    k_out[i] = 1'b1;
                    if ((b == CODE_S && i == 0) || b == CODE_T || b == CODE_E || b == CODE_Q) begin
                        data_out[8*i +: 8] = b;
                    end else if (b == CODE_I) begin
                        data_out[8*i +: 8] = CODE_K;
                    end else begin
                        data_out[8*i +: 8] = CODE_E;
                        err                = 1'b1;
                    end
                end
            end
        end

        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_cur)
                ST_IDLE:   if (has_s0) state_next = ST_PKT;
                ST_PKT:    if (has_t) state_next = ST_POST_T;
                ST_POST_T: begin
                    if (has_s0)        state_next = ST_PKT;
                    else if (idle_col) state_next = ST_IDLE;
                end
                default:   state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/xaui_tx_idle_gen.sv
// XGMII-to-XAUI transmit idle generator: two chained column encoders between an
// input register stage and an output register stage (2-cycle latency).
module xaui_tx_idle_gen
    import xaui_pkg::*;
#(
    parameter logic [6:0] LFSR_SEED = 7'h7F,
    parameter int         A_MIN     = 16
) (
    input  logic        mgt_clk,
    input  logic        mgt_reset_n,
    input  logic        tx_en,
    input  logic [63:0] xgmii_txd,
    input  logic [7:0]  xgmii_txc,
    output logic [63:0] mgt_txdata,
    output logic [7:0]  mgt_txcharisk,
    output logic        code_err
);

    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        en_q, en_d;

    col_state_e  state_q, state_d;
    logic [4:0]  a_cnt_q, a_cnt_d;
    logic [6:0]  lfsr_q, lfsr_d;

    logic [63:0] txdata_q, txdata_d;
    logic [7:0]  txk_q, txk_d;
    logic        err_q, err_d;

    logic [31:0] d0, d1;
    logic [3:0]  k0, k1;
    logic        e0, e1;
    logic [1:0]  st1, st2;
    logic [4:0]  acnt1, acnt2;
    logic [6:0]  lfsr1;

    assign lfsr1 = lfsr_step(lfsr_q);

    xaui_col_enc #(.A_MIN(A_MIN)) u_enc0 (
        .en         (en_q),
        .state_in   (state_q),
        .a_cnt      (a_cnt_q),
        .lfsr       (lfsr_q[3:0]),
        .txd        (txd_q[31:0]),
        .txc        (txc_q[3:0]),
        .data_out   (d0),
        .k_out      (k0),
        .err        (e0),
        .state_out  (st1),
        .a_cnt_next (acnt1)
    );

    xaui_col_enc #(.A_MIN(A_MIN)) u_enc1 (
        .en         (en_q),
        .state_in   (st1),
        .a_cnt      (acnt1),
        .lfsr       (lfsr1[3:0]),
        .txd        (txd_q[63:32]),
        .txc        (txc_q[7:4]),
        .data_out   (d1),
        .k_out      (k1),
        .err        (e1),
        .state_out  (st2),
        .a_cnt_next (acnt2)
    );

    always_comb begin
        txd_d    = xgmii_txd;
        txc_d    = xgmii_txc;
        en_d     = tx_en;
        state_d  = col_state_e'(st2);
        a_cnt_d  = acnt2;
        lfsr_d   = lfsr_step(lfsr1);
        err_d    = e0 | e1;
        txdata_d = '0;
        txk_d    = '0;
        // Each lane carries column 0 in its low byte and column 1 in its high byte.
        for (int i = 0; i < 4; i++) begin
            txdata_d[16*i +: 16] = {d1[8*i +: 8], d0[8*i +: 8]};
            txk_d[2*i +: 2]      = {k1[i], k0[i]};
        end
    end

    always_ff @(posedge mgt_clk or negedge mgt_reset_n) begin
        if (!mgt_reset_n) begin
            txd_q    <= {8{CODE_I}};
            txc_q    <= 8'hFF;
            en_q     <= 1'b0;
            state_q  <= ST_IDLE;
            a_cnt_q  <= 5'd0;
            lfsr_q   <= LFSR_SEED;
            txdata_q <= {8{CODE_K}};
            txk_q    <= 8'hFF;
            err_q    <= 1'b0;
        end else begin
            txd_q    <= txd_d;
            txc_q    <= txc_d;
            en_q     <= en_d;
            state_q  <= state_d;
            a_cnt_q  <= a_cnt_d;
            lfsr_q   <= lfsr_d;
            txdata_q <= txdata_d;
            txk_q    <= txk_d;
            err_q    <= err_d;
        end
    end

    assign mgt_txdata    = txdata_q;
    assign mgt_txcharisk = txk_q;
    assign code_err      = err_q;

endmodule

// File: tb/tb_xaui_tx_idle_gen.sv
// Scoreboard bench for xaui_tx_idle_gen: a column-level reference model predicts each
// cycle's output when the stimulus is driven; tests compare when it emerges.
module tb_xaui_tx_idle_gen;

    logic        mgt_clk = 1'b0;
    logic        mgt_reset_n = 1'b1;
    logic        tx_en = 1'b1;
    logic [63:0] xgmii_txd = {8{8'h07}};
    logic [7:0]  xgmii_txc = 8'hFF;
    logic [63:0] mgt_txdata;
    logic [7:0]  mgt_txcharisk;
    logic        code_err;

    localparam logic [63:0] IDLE_D = {8{8'h07}};

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_v;

    int         m_state;
    int         m_acnt;
    logic [6:0] m_lfsr;

    xaui_tx_idle_gen #(.LFSR_SEED(7'h7F), .A_MIN(16)) dut (
        .mgt_clk       (mgt_clk),
        .mgt_reset_n   (mgt_reset_n),
        .tx_en         (tx_en),
        .xgmii_txd     (xgmii_txd),
        .xgmii_txc     (xgmii_txc),
        .mgt_txdata    (mgt_txdata),
        .mgt_txcharisk (mgt_txcharisk),
        .code_err      (code_err)
    );

    always #5 mgt_clk = ~mgt_clk;

    task automatic model_col(input logic [31:0] d, input logic [3:0] c, input logic en,
                             output logic [31:0] od, output logic [3:0] ok, output logic oe);
        logic full, t_seen, s0;
        logic [7:0] code, b;
        full   = !en || (c == 4'hF && d == 32'h07070707);
        s0     = en && c[0] && d[7:0] == 8'hFB;
        t_seen = 1'b0;
        od = '0; ok = '0; oe = 1'b0; code = 8'h00;
        for (int i = 0; i < 4; i++)
            if (en && c[i] && d[8*i +: 8] == 8'hFD) t_seen = 1'b1;
        if (full) begin
            if (m_acnt == 0) begin
                code   = 8'h7C;
                m_acnt = 16 + int'(m_lfsr[3:0]);
            end else if (m_state == 2 || m_lfsr[0]) code = 8'hBC;
            else code = 8'h1C;
            od = {4{code}};
            ok = 4'hF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                b = d[8*i +: 8];
                if (!c[i]) od[8*i +: 8] = b;
                else begin
                    ok[i] = 1'b1;
                    case (b)
                        8'hFD, 8'hFE, 8'h9C: od[8*i +: 8] = b;
                        8'hFB: if (i == 0) od[8*i +: 8] = b; else begin od[8*i +: 8] = 8'hFE; oe = 1'b1; end
                        8'h07: od[8*i +: 8] = 8'hBC;
                        default: begin od[8*i +: 8] = 8'hFE; oe = 1'b1; end
                    endcase
                end
            end
        end
        if (!en)                          m_state = 0;
        else if (m_state == 0 && s0)      m_state = 1;
        else if (m_state == 1 && t_seen)  m_state = 2;
        else if (m_state == 2 && s0)      m_state = 1;
        else if (m_state == 2 && full)    m_state = 0;
        if (m_acnt > 0) m_acnt = m_acnt - 1;
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    endtask

    task automatic model_push(input logic [63:0] d, input logic [7:0] c, input logic en);
        logic [31:0] od0, od1;
        logic [3:0]  ok0, ok1;
        logic        oe0, oe1;
        exp_t        e;
        model_col(d[31:0], c[3:0], en, od0, ok0, oe0);
        model_col(d[63:32], c[7:4], en, od1, ok1, oe1);
        e.e = oe0 | oe1;
        for (int i = 0; i < 4; i++) begin
            e.d[16*i +: 16] = {od1[8*i +: 8], od0[8*i +: 8]};
            e.k[2*i +: 2]   = {ok1[i], ok0[i]};
        end
        sb_q.push_back(e);
    endtask

    // Drive one cycle of input; afterwards exp_v holds the prediction for the current output.
    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic en);
        model_push(d, c, en);
        xgmii_txd = d;
        xgmii_txc = c;
        tx_en     = en;
        @(posedge mgt_clk);
        #1;
        exp_v = sb_q.pop_front();
    endtask

    task automatic reset_release();
        m_state = 0;
        m_acnt  = 0;
        m_lfsr  = 7'h7F;
        sb_q.delete();
        mgt_reset_n = 1'b1;
        // The input stage leaves reset holding an idle column.
        model_push(IDLE_D, 8'hFF, 1'b0);
    endtask

    task automatic test_reset();
        xgmii_txd = IDLE_D; xgmii_txc = 8'hFF; tx_en = 1'b1;
        #2 mgt_reset_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge mgt_clk);
            #1;
            if ({mgt_txdata, mgt_txcharisk, code_err} !== {64'hBCBC_BCBC_BCBC_BCBC, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL reset_out n=%0d got=%h/%h/%b exp=bcbcbcbcbcbcbcbc/ff/0", n, mgt_txdata, mgt_txcharisk, code_err);
            end
            checks++;
        end
        reset_release();
    endtask

    task automatic test_idle();
        int colno = 0;
        int a_last = -1;
        logic [7:0] code;
        for (int n = 0; n < 90; n++) begin
            step(IDLE_D, 8'hFF, 1'b1);
            if ({mgt_txdata, mgt_txcharisk, code_err} !== exp_v) begin
                failures++;
                $display("FAIL idle_sb n=%0d got=%h/%h/%b exp=%h/%h/%b", n, mgt_txdata, mgt_txcharisk, code_err, exp_v.d, exp_v.k, exp_v.e);
            end
            checks++;
            for (int col = 0; col < 2; col++) begin
                code = mgt_txdata[8*col +: 8];
                if (code == 8'h7C) begin
                    if (a_last < 0) begin
                        if (colno != 0) begin
                            failures++;
                            $display("FAIL idle_first_a got_col=%0d exp_col=0", colno);
                        end
                        checks++;
                    end else begin
                        if (colno - a_last < 16 || colno - a_last > 31) begin
                            failures++;
                            $display("FAIL idle_a_gap got=%0d exp=16..31", colno - a_last);
                        end
                        checks++;
                    end
                    a_last = colno;
                end else if (a_last < 0) begin
                    failures++;
                    $display("FAIL idle_first_a got=%h at col %0d exp=7c", code, colno);
                    checks++;
                    a_last = colno;
                end
                colno++;
            end
        end
    endtask

    task automatic test_packet();
        logic [63:0] pd[8];
        logic [7:0]  pc[8];
        pd[0] = {32'h77665544, 32'h332211FB}; pc[0] = 8'h01;
        pd[1] = {32'h070707FD, 32'hBBAA9988}; pc[1] = 8'hF0;
        pd[2] = IDLE_D;                       pc[2] = 8'hFF;
        pd[3] = {32'hDDCCBBFB, IDLE_D[31:0]}; pc[3] = 8'h1F;
        pd[4] = {32'h665544FB, 32'h070707FD}; pc[4] = 8'h1F;
        pd[5] = {32'h07FD2211, 32'h44332211}; pc[5] = 8'hC0;
        pd[6] = IDLE_D;                       pc[6] = 8'hFF;
        pd[7] = IDLE_D;                       pc[7] = 8'hFF;
        for (int n = 0; n < 8; n++) begin
            step(pd[n], pc[n], 1'b1);
            if ({mgt_txdata, mgt_txcharisk, code_err} !== exp_v) begin
                failures++;
                $display("FAIL pkt_sb n=%0d got=%h/%h/%b exp=%h/%h/%b", n, mgt_txdata, mgt_txcharisk, code_err, exp_v.d, exp_v.k, exp_v.e);
            end
            checks++;
            if (n == 1) begin
                if ({mgt_txdata, mgt_txcharisk} !== {64'h7733_6622_5511_44FB, 8'h01}) begin
                    failures++;
                    $display("FAIL pkt_start got=%h/%h exp=7733662255114 4fb/01", mgt_txdata, mgt_txcharisk);
                end
                checks++;
            end
            if (n == 2) begin
                if ({mgt_txdata[63:56], mgt_txdata[47:40], mgt_txdata[31:24], mgt_txdata[15:8], mgt_txcharisk} !==
                    {8'hBC, 8'hBC, 8'hBC, 8'hFD, 8'hAA}) begin
                    failures++;
                    $display("FAIL pkt_t_col got=%h/%h", mgt_txdata, mgt_txcharisk);
                end
                checks++;
            end
            if (n == 3) begin
                if (mgt_txdata[7:0] !== 8'hBC && mgt_txdata[7:0] !== 8'h7C) begin
                    failures++;
                    $display("FAIL pkt_post_t_idle got=%h exp=bc or 7c", mgt_txdata[7:0]);
                end
                checks++;
            end
            if (n == 5) begin
                if ({mgt_txdata[15:8], mgt_txcharisk[1], code_err} !== {8'hFB, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL b2b_s got=%h/%b/%b exp=fb/1/0", mgt_txdata[15:8], mgt_txcharisk[1], code_err);
                end
                checks++;
            end
        end
    endtask

    task automatic test_bad_ctrl();
        logic [63:0] bd[4];
        logic [7:0]  bc[4];
        bd[0] = {IDLE_D[31:0], 32'hCC55BBAA}; bc[0] = 8'hF4;
        bd[1] = IDLE_D;                       bc[1] = 8'hFF;
        bd[2] = {IDLE_D[31:0], 32'h0707FB07}; bc[2] = 8'hFF;
        bd[3] = IDLE_D;                       bc[3] = 8'hFF;
        for (int n = 0; n < 4; n++) begin
            step(bd[n], bc[n], 1'b1);
            if ({mgt_txdata, mgt_txcharisk, code_err} !== exp_v) begin
                failures++;
                $display("FAIL bad_sb n=%0d got=%h/%h/%b exp=%h/%h/%b", n, mgt_txdata, mgt_txcharisk, code_err, exp_v.d, exp_v.k, exp_v.e);
            end
            checks++;
        end
        step(IDLE_D, 8'hFF, 1'b1);
        step(bd[0], bc[0], 1'b1);
        step(IDLE_D, 8'hFF, 1'b1);
        if ({mgt_txdata[39:32], mgt_txcharisk[4], code_err} !== {8'hFE, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bad_ctrl_lane2 got=%h/%b/%b exp=fe/1/1", mgt_txdata[39:32], mgt_txcharisk[4], code_err);
        end
        checks++;
        step(IDLE_D, 8'hFF, 1'b1);
        if (code_err !== 1'b0) begin
            failures++;
            $display("FAIL bad_ctrl_pulse got=%b exp=0", code_err);
        end
        checks++;
    endtask

    task automatic test_tx_en();
        logic [63:0] d;
        logic [7:0]  c;
        logic        en;
        for (int n = 0; n < 14; n++) begin
            en = !(n >= 2 && n <= 5);
            if (n == 0 || n == 8)       begin d = {32'h44332211, 32'hA1B2C3FB}; c = 8'h01; end
            else if (n >= 1 && n <= 5)  begin d = {$urandom, $urandom}; c = 8'h00; end
            else if (n == 9)            begin d = {32'h070707FD, 32'h99887766}; c = 8'hF0; end
            else                        begin d = IDLE_D; c = 8'hFF; end
            step(d, c, en);
            if ({mgt_txdata, mgt_txcharisk, code_err} !== exp_v) begin
                failures++;
                $display("FAIL txen_sb n=%0d got=%h/%h/%b exp=%h/%h/%b", n, mgt_txdata, mgt_txcharisk, code_err, exp_v.d, exp_v.k, exp_v.e);
            end
            checks++;
            if (n >= 3 && n <= 6) begin
                for (int i = 0; i < 8; i++) begin
                    if (!(mgt_txdata[8*i +: 8] inside {8'hBC, 8'h1C, 8'h7C}) || mgt_txcharisk !== 8'hFF) begin
                        failures++;
                        $display("FAIL txen_idle n=%0d byte=%0d got=%h/%h exp=bc|1c|7c/ff", n, i, mgt_txdata[8*i +: 8], mgt_txcharisk);
                    end
                    checks++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step({32'h44332211, 32'h302010FB}, 8'h01, 1'b1);
        step({32'h88776655, 32'hCCBBAA99}, 8'h00, 1'b1);
        #2 mgt_reset_n = 1'b0;
        #1;
        if ({mgt_txdata, mgt_txcharisk, code_err} !== {64'hBCBC_BCBC_BCBC_BCBC, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL rst_mid_async got=%h/%h/%b exp=bcbcbcbcbcbcbcbc/ff/0", mgt_txdata, mgt_txcharisk, code_err);
        end
        checks++;
        xgmii_txd = {32'h070707FD, 32'h11111111}; xgmii_txc = 8'hF0;
        repeat (3) @(posedge mgt_clk);
        #1;
        reset_release();
        for (int n = 0; n < 6; n++) begin
            step(IDLE_D, 8'hFF, 1'b1);
            if ({mgt_txdata, mgt_txcharisk, code_err} !== exp_v) begin
                failures++;
                $display("FAIL rst_mid_sb n=%0d got=%h/%h/%b exp=%h/%h/%b", n, mgt_txdata, mgt_txcharisk, code_err, exp_v.d, exp_v.k, exp_v.e);
            end
            checks++;
            if (n == 0) begin
                if ({mgt_txdata[7:0], mgt_txdata[23:16], mgt_txdata[39:32], mgt_txdata[55:48]} !== {4{8'h7C}}) begin
                    failures++;
                    $display("FAIL rst_mid_first_a got=%h exp=7c on column 0", mgt_txdata);
                end
                checks++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_packet();
        test_bad_ctrl();
        test_tx_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
